reset_release_sequencer: RTL

//  Orders reset release across NUM_STAGES downstream blocks after global reset deassertion.
//  - Stage i is released only after stage i-1 is released, has acknowledged, and STAGE_DLY cycles elapse.
//  - A missing acknowledge sets a sticky error.
//  - A software request restarts the whole sequence.
//  - Sits between the board reset and per-block reset inputs. Its outputs are the targets of the timing assertions in the SVA suite.

---
 rtl/rst_seq_pkg.sv | 24 ++
 rtl/seq_dly_counter.sv | 23 ++
 rtl/reset_release_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration helpers for the reset release sequencer.
// Holds only FSM encoding and width/target arithmetic; no logic.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    INIT_WAIT = 3'd0,
    WAIT_ACK  = 3'd1,
    GAP       = 3'd2,
    DONE      = 3'd3,
    ERR       = 3'd4
  } seq_state_t;

  // One extra bit so a single-stage build still has a non-zero-width index.
  function automatic int stage_idx_w(input int num_stages);
    return $clog2(num_stages) + 1;
  endfunction

  // The counter starts at 0 on the first counted cycle, so a delay of N
  // cycles expires when it reads N-1; zero and one both mean "next edge".
  function automatic int dly_target(input int dly);
    return (dly == 0) ? 0 : dly - 1;
  endfunction

endpackage

// File: rtl/seq_dly_counter.sv
// Shared delay/timeout counter: synchronous clear, count enable, saturates at all-ones.
// One cycle from clr/en to updated cnt; no flow control.
module seq_dly_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reset_release_sequencer.sv
// Releases NUM_STAGES downstream resets in order, waiting for each ack plus a gap.
// All outputs are registered; sw_rst_req restarts the sequence on the next edge.
module reset_release_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int CNT_W       = 8,
  parameter int INIT_DLY    = 5,
  parameter int STAGE_DLY   = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sw_rst_req,
  input  logic [NUM_STAGES-1:0]               stage_ack,
  output logic [NUM_STAGES-1:0]               stage_rel,
  output logic [stage_idx_w(NUM_STAGES)-1:0]  cur_stage,
  output logic                                seq_done,
  output logic                                timeout_err
);

  localparam int SW = stage_idx_w(NUM_STAGES);
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  localparam logic [SW-1:0]    LAST_STAGE = SW'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] INIT_TGT   = CNT_W'(dly_target(INIT_DLY));
  localparam logic [CNT_W-1:0] GAP_TGT    = CNT_W'(dly_target(STAGE_DLY));
  localparam logic [CNT_W-1:0] ACK_TGT    = CNT_W'(dly_target(ACK_TIMEOUT));

  if (NUM_STAGES < 1) begin : g_bad_stages
    $error("reset_release_sequencer: NUM_STAGES must be at least 1");
  end

  if ((INIT_DLY > CNT_MAX) || (STAGE_DLY > CNT_MAX) || (ACK_TIMEOUT > CNT_MAX)) begin : g_bad_dly
    $error("reset_release_sequencer: delay parameter does not fit in CNT_W bits");
  end

  seq_state_t            state_q;
  seq_state_t            state_n;
  logic [NUM_STAGES-1:0] rel_n;
  logic [SW-1:0]         cur_n;
  logic                  done_n;
  logic                  err_n;

  logic                  cnt_clr;
  logic                  cnt_en;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_tgt;
  logic                  expired;

  logic                  ack_cur;
  logic [NUM_STAGES-1:0] next_mask;

  seq_dly_counter #(
    .CNT_W (CNT_W)
  ) u_dly_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (cnt)
  );

  // One counter serves all three waits; the target follows the state.
  always_comb begin
    cnt_tgt = '0;
    case (state_q)
      INIT_WAIT: cnt_tgt = INIT_TGT;
      WAIT_ACK:  cnt_tgt = ACK_TGT;
      GAP:       cnt_tgt = GAP_TGT;
      default:   cnt_tgt = '0;
    endcase
  end

  assign expired = (cnt == cnt_tgt);

  // Loop-based selects avoid an index wider than the stage vector.
  always_comb begin
    ack_cur   = 1'b0;
    next_mask = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (cur_stage == SW'(i)) begin
        ack_cur = stage_ack[i];
      end
      if ((cur_stage + SW'(1)) == SW'(i)) begin
        next_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    rel_n   = stage_rel;
    cur_n   = cur_stage;
    done_n  = seq_done;
    err_n   = timeout_err;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    if (sw_rst_req) begin
      state_n = INIT_WAIT;
      rel_n   = '0;
      cur_n   = '0;
      done_n  = 1'b0;
      err_n   = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        INIT_WAIT: begin
          if (expired) begin
            state_n  = WAIT_ACK;
            rel_n[0] = 1'b1;
            cur_n    = '0;
            cnt_clr  = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end

        WAIT_ACK: begin
          if (ack_cur) begin
            cnt_clr = 1'b1;
            if (cur_stage == LAST_STAGE) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else begin
              state_n = GAP;
            end
          end else if (expired) begin
            state_n = ERR;
            err_n   = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end

        GAP: begin
          if (expired) begin
            state_n = WAIT_ACK;
            rel_n   = stage_rel | next_mask;
            cur_n   = cur_stage + SW'(1);
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end

        // Releases stay frozen so the failing stage can be inspected.
        ERR: begin
          done_n = 1'b0;
        end

        DONE: begin
          state_n = DONE;
        end

        default: begin
          state_n = INIT_WAIT;
          rel_n   = '0;
          cur_n   = '0;
          done_n  = 1'b0;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT_WAIT;
      stage_rel   <= '0;
      cur_stage   <= '0;
      seq_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_n;
      stage_rel   <= rel_n;
      cur_stage   <= cur_n;
      seq_done    <= done_n;
      timeout_err <= err_n;
    end
  end

endmodule
